alu_ctrl_pipe: RTL and testbench
================================

// Module: alu_ctrl_pipe
// PURPOSE
//  Registered ALU-control stage between ID and EX. Decodes ALUOp/FuncField into an ALU Operation and branch_type.
//  Holds the result in a valid/ready output register.
//  Stalls upstream for multi-cycle mul/div ops via an internal latency counter, so EX sees the op only when complete.
// PARAMETERS
//  ALUOP_W     4  width of ALUOp
//  FUNC_W      6  width of FuncField
//  OP_W        4  width of Operation
//  MUL_CYCLES  3  cycles from accept to out_valid for mul (>=1)
//  DIV_CYCLES  8  cycles from accept to out_valid for div (>=1)
//  CNT_W       $clog2(max(MUL_CYCLES,DIV_CYCLES))+1  latency counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  flush        in   1        synchronous pipeline flush
//  in_valid     in   1        ALUOp/FuncField valid
//  in_ready     out  1        stage can accept
//  ALUOp        in   ALUOP_W  main-decoder op class
//  FuncField    in   FUNC_W   R-type funct
//  out_valid    out  1        Operation/branch_type valid to EX
//  out_ready    in   1        EX consumes
//  Operation    out  OP_W     ALU operation code
//  branch_type  out  3        0=none, 1=beq, 2=bne, 3=bgt, 4=blt, 5=bge, 6=ble
//  multi_busy   out  1        mul/div latency count in progress
//  illegal      out  1        only with ALU_ILLEGAL_TRAP_EN
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; out_valid, Operation, branch_type, multi_busy, illegal = 0; counter = 0.
//  Decode (combinational, alu_ctrl_decode):
//   - ALUOp 0000 -> add 0000.
//   - ALUOp 0001 -> and 1000; ALUOp 0011 -> or 1001.
//   - ALUOp 0010 -> funct table:
//     add 100000->0000, sub 100010->0001, mul 011000->0010, div 011010->0011,
//     sll 000000->0100, srl 000010->0101, and 100100->1000, or 100101->1001,
//     xor 100110->1010, nor 100111->1011, slt 101010->1110, addu 100001->0110,
//     subu 100011->0111.
//   - Branches (Operation, branch_type): 0100 beq (0001,1); 0101 bne (0001,2); 0110 bgt (1110,3);
//     0111 blt (1101,4); 1000 bge (1100,5); 1001 ble (1100,6).
//   - Every non-branch op drives branch_type=0; no value is held from a previous op.
//   - Any other ALUOp -> Operation 1111.
//  FSM (accept = in_valid & in_ready):
//   - IDLE: in_ready=1, out_valid=0. Accept of a 1-cycle op -> VALID. Accept of mul/div with LAT>1 -> BUSY, cnt=LAT-2.
//     Operation and branch_type are registered on accept.
//   - BUSY: in_ready=0, out_valid=0, multi_busy=1. cnt decrements each cycle; at cnt==0 -> VALID.
//   - VALID: out_valid=1, in_ready=out_ready.
//     out_ready & in_valid -> back-to-back accept: VALID or BUSY, per the new op.
//     out_ready & !in_valid -> IDLE. !out_ready -> hold all outputs stable.
//  Latency, accept to out_valid: 1 cycle for 1-cycle ops; MUL_CYCLES / DIV_CYCLES for mul / div.
//   - LAT=1 behaves as a 1-cycle op.
//  Throughput: 1 op/cycle with out_ready held high and no mul/div.
//  flush: highest priority. Next state IDLE; out_valid, multi_busy = 0; counter cleared.
//   - Operation and branch_type are cleared to 0.
//   - A same-cycle in_valid is dropped; in_ready is not gated by flush.
//  Reset mid-BUSY aborts immediately (async). No partial op reaches EX.
//  in_ready depends only on state and out_ready; there is no combinational in_valid->in_ready path.
// CONFIGURATION
//  ALU_ILLEGAL_TRAP_EN defined:
//   - ALUOp 0010 with an unlisted funct, or an unlisted ALUOp, registers illegal=1 alongside Operation.
//   - The illegal op is still passed through VALID; illegal clears on the next accept/flush/reset.
//  Not defined:
//   - No illegal port. An unlisted funct decodes to add 0000; an unlisted ALUOp decodes to 1111.
// STRUCTURE
//  alu_ctrl_pkg: ALUOp codes, funct codes, Operation codes, branch_type codes, FSM state encodings.
//  Sub-module alu_ctrl_decode: pure combinational decode -> {Operation, branch_type, is_multi, is_mul, illegal}.
//  Top level holds the FSM, latency counter and output registers.
// TESTING
//  1. Reset, then add funct 100000, out_ready=1 -> out_valid next cycle, Operation=0000, branch_type=0.
//  2. mul 011000, MUL_CYCLES=3 -> multi_busy 2 cycles, in_ready=0, out_valid on cycle 3, Operation=0010.
//  3. beq then andi back-to-back, out_ready=1 -> (0001,1) then (1000,0); branch_type does not persist.
//  4. out_ready=0 for 4 cycles in VALID -> outputs stable, in_ready=0; release -> next op accepted same cycle.
//  5. flush during div BUSY (DIV_CYCLES=8, cycle 4) -> IDLE next cycle, out_valid never asserted, Operation=0.
//  6. ALUOp 0010, funct 111111:
//     - with ALU_ILLEGAL_TRAP_EN -> illegal=1, Operation=0000;
//     - without -> Operation=0000, no illegal port.
//     Also drop rst_n mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU-control pipeline stage: ALUOp classes, R-type funct
// values, ALU operation codes, branch kinds and the stage FSM encoding.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALUOP_ADD   = 4'b0000,
        ALUOP_ANDI  = 4'b0001,
        ALUOP_RTYPE = 4'b0010,
        ALUOP_ORI   = 4'b0011,
        ALUOP_BEQ   = 4'b0100,
        ALUOP_BNE   = 4'b0101,
        ALUOP_BGT   = 4'b0110,
        ALUOP_BLT   = 4'b0111,
        ALUOP_BGE   = 4'b1000,
        ALUOP_BLE   = 4'b1001
    } aluop_e;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_MUL  = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    typedef enum logic [3:0] {
        OP_ADD     = 4'b0000,
        OP_SUB     = 4'b0001,
        OP_MUL     = 4'b0010,
        OP_DIV     = 4'b0011,
        OP_SLL     = 4'b0100,
        OP_SRL     = 4'b0101,
        OP_ADDU    = 4'b0110,
        OP_SUBU    = 4'b0111,
        OP_AND     = 4'b1000,
        OP_OR      = 4'b1001,
        OP_XOR     = 4'b1010,
        OP_NOR     = 4'b1011,
        OP_GE      = 4'b1100,
        OP_LT      = 4'b1101,
        OP_SLT     = 4'b1110,
        OP_INVALID = 4'b1111
    } op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGT  = 3'd3,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLE  = 3'd6
    } br_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_VALID = 2'b10
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALUOp/funct decode into ALU operation, branch kind,
// multi-cycle flags and an unlisted-encoding flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int FUNC_W  = 6,
    parameter int OP_W    = 4
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [FUNC_W-1:0]  funct,
    output logic [OP_W-1:0]    operation,
    output logic [2:0]         branch_type,
    output logic               is_multi,
    output logic               is_mul,
    output logic               illegal
);

    always_comb begin
        operation   = OP_W'(OP_ADD);
        branch_type = BR_NONE;
        is_multi    = 1'b0;
        is_mul      = 1'b0;
        illegal     = 1'b0;
        case (aluop)
            ALUOP_W'(ALUOP_ADD):  operation = OP_W'(OP_ADD);
            ALUOP_W'(ALUOP_ANDI): operation = OP_W'(OP_AND);
            ALUOP_W'(ALUOP_ORI):  operation = OP_W'(OP_OR);
            ALUOP_W'(ALUOP_RTYPE): begin
                case (funct)
                    FUNC_W'(FN_ADD):  operation = OP_W'(OP_ADD);
                    FUNC_W'(FN_SUB):  operation = OP_W'(OP_SUB);
                    FUNC_W'(FN_MUL): begin
                        operation = OP_W'(OP_MUL);
                        is_multi  = 1'b1;
                        is_mul    = 1'b1;
                    end
                    FUNC_W'(FN_DIV): begin
                        operation = OP_W'(OP_DIV);
                        is_multi  = 1'b1;
                    end
                    FUNC_W'(FN_SLL):  operation = OP_W'(OP_SLL);
                    FUNC_W'(FN_SRL):  operation = OP_W'(OP_SRL);
                    FUNC_W'(FN_AND):  operation = OP_W'(OP_AND);
                    FUNC_W'(FN_OR):   operation = OP_W'(OP_OR);
                    FUNC_W'(FN_XOR):  operation = OP_W'(OP_XOR);
                    FUNC_W'(FN_NOR):  operation = OP_W'(OP_NOR);
                    FUNC_W'(FN_SLT):  operation = OP_W'(OP_SLT);
                    FUNC_W'(FN_ADDU): operation = OP_W'(OP_ADDU);
                    FUNC_W'(FN_SUBU): operation = OP_W'(OP_SUBU);
                    // Unknown funct falls back to add so the pipe keeps moving.
                    default:          illegal   = 1'b1;
                endcase
            end
            ALUOP_W'(ALUOP_BEQ): begin
                operation   = OP_W'(OP_SUB);
                branch_type = BR_BEQ;
            end
            ALUOP_W'(ALUOP_BNE): begin
                operation   = OP_W'(OP_SUB);
                branch_type = BR_BNE;
            end
            ALUOP_W'(ALUOP_BGT): begin
                operation   = OP_W'(OP_SLT);
                branch_type = BR_BGT;
            end
            ALUOP_W'(ALUOP_BLT): begin
                operation   = OP_W'(OP_LT);
                branch_type = BR_BLT;
            end
            ALUOP_W'(ALUOP_BGE): begin
                operation   = OP_W'(OP_GE);
                branch_type = BR_BGE;
            end
            ALUOP_W'(ALUOP_BLE): begin
                operation   = OP_W'(OP_GE);
                branch_type = BR_BLE;
            end
            default: begin
                operation = OP_W'(OP_INVALID);
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control stage between ID and EX with valid/ready handshake and
// mul/div latency stall. Optional illegal-op flag: ALU_ILLEGAL_TRAP_EN.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 4,
    parameter int FUNC_W     = 6,
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNC_W-1:0]  FuncField,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    Operation,
    output logic [2:0]         branch_type,
    output logic               multi_busy
`ifdef ALU_ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

    // A latency of N means N-1 BUSY cycles; the counter is loaded with N-2 so
    // that the BUSY->VALID transition happens on the cycle it reads zero.
    localparam bit               MUL_LONG = (MUL_CYCLES > 1);
    localparam bit               DIV_LONG = (DIV_CYCLES > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = MUL_LONG ? CNT_W'(MUL_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] DIV_LOAD = DIV_LONG ? CNT_W'(DIV_CYCLES - 2) : '0;

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [OP_W-1:0]    op_reg, op_next;
    logic [2:0]         bt_reg, bt_next;

    logic [OP_W-1:0]    dec_op;
    logic [2:0]         dec_bt;
    logic               dec_is_multi;
    logic               dec_is_mul;
    logic               dec_long;
    logic [CNT_W-1:0]   dec_load;
    logic               accept;

`ifdef ALU_ILLEGAL_TRAP_EN
    logic               dec_illegal;
    logic               ill_reg, ill_next;
`else
    logic               dec_illegal_unused;
`endif

    alu_ctrl_decode #(
        .ALUOP_W (ALUOP_W),
        .FUNC_W  (FUNC_W),
        .OP_W    (OP_W)
    ) u_decode (
        .aluop       (ALUOp),
        .funct       (FuncField),
        .operation   (dec_op),
        .branch_type (dec_bt),
        .is_multi    (dec_is_multi),
        .is_mul      (dec_is_mul),
`ifdef ALU_ILLEGAL_TRAP_EN
        .illegal     (dec_illegal)
`else
        .illegal     (dec_illegal_unused)
`endif
    );

    // in_ready is a function of state and out_ready only, never of in_valid.
    assign in_ready    = (state_reg == ST_IDLE) || ((state_reg == ST_VALID) && out_ready);
    assign out_valid   = (state_reg == ST_VALID);
    assign multi_busy  = (state_reg == ST_BUSY);
    assign Operation   = op_reg;
    assign branch_type = bt_reg;
`ifdef ALU_ILLEGAL_TRAP_EN
    assign illegal     = ill_reg;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        bt_next    = bt_reg;
`ifdef ALU_ILLEGAL_TRAP_EN
        ill_next   = ill_reg;
`endif
        accept   = in_valid && in_ready;
        dec_long = dec_is_mul ? MUL_LONG : DIV_LONG;
        dec_load = dec_is_mul ? MUL_LOAD : DIV_LOAD;

        if (flush) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            op_next    = '0;
            bt_next    = '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            ill_next   = 1'b0;
`endif
        end else if (accept) begin
            // Covers both the IDLE accept and the back-to-back accept from VALID.
            op_next = dec_op;
            bt_next = dec_bt;
`ifdef ALU_ILLEGAL_TRAP_EN
            ill_next = dec_illegal;
`endif
            if (dec_is_multi && dec_long) begin
                state_next = ST_BUSY;
                cnt_next   = dec_load;
            end else begin
                state_next = ST_VALID;
                cnt_next   = '0;
            end
        end else begin
            case (state_reg)
                ST_BUSY: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_VALID;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_IDLE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            bt_reg    <= '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            ill_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            bt_reg    <= bt_next;
`ifdef ALU_ILLEGAL_TRAP_EN
            ill_reg   <= ill_next;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe: directed scenarios plus randomized traffic,
// checked against a table-driven reference model.
`timescale 1ns/1ps
module tb_alu_ctrl_pipe;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] ALUOp = 4'd0;
    logic [5:0] FuncField = 6'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] Operation;
    logic [2:0] branch_type;
    logic       multi_busy;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_ctrl_pipe #(
        .MUL_CYCLES (MUL_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUOp       (ALUOp),
        .FuncField   (FuncField),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Operation   (Operation),
        .branch_type (branch_type),
        .multi_busy  (multi_busy)
`ifdef ALU_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model tables.
    logic [3:0] rt_map [logic [5:0]];
    logic [3:0] br_op [6] = '{4'b0001, 4'b0001, 4'b1110, 4'b1101, 4'b1100, 4'b1100};
    logic [5:0] fn_list [13] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b000000,
                                 6'b000010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                 6'b101010, 6'b100001, 6'b100011};

    typedef struct {
        logic [3:0] op;
        logic [2:0] bt;
        logic       ill;
        int         due;
        bit         seen;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected response for an op accepted on clock edge accept_edge; it becomes
    // visible after edge accept_edge + latency - 1.
    function automatic exp_t model(input logic [3:0] a, input logic [5:0] f, input int accept_edge);
        exp_t e;
        int lat;
        lat    = 1;
        e.op   = 4'b0000;
        e.bt   = 3'd0;
        e.ill  = 1'b0;
        e.seen = 1'b0;
        if (a == 4'd0) e.op = 4'b0000;
        else if (a == 4'd1) e.op = 4'b1000;
        else if (a == 4'd3) e.op = 4'b1001;
        else if (a == 4'd2) begin
            if (rt_map.exists(f)) e.op = rt_map[f];
            else e.ill = 1'b1;
            if (f == 6'b011000) lat = MUL_LAT;
            if (f == 6'b011010) lat = DIV_LAT;
        end else if (a >= 4'd4 && a <= 4'd9) begin
            e.op = br_op[int'(a) - 4];
            e.bt = 3'(int'(a) - 3);
        end else begin
            e.op  = 4'b1111;
            e.ill = 1'b1;
        end
        e.due = accept_edge + lat - 1;
        return e;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    bit post_flush = 1'b0;
    int idle_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            post_flush = 1'b0;
            idle_cnt = 0;
        end else begin
            if (post_flush) begin
                post_flush = 1'b0;
                chk("flush_clear", 32'({out_valid, multi_busy, Operation, branch_type}), 0);
            end
            if (out_valid && multi_busy) chk("valid_and_busy", 32'(multi_busy), 0);
            if (out_valid) begin
                idle_cnt = 0;
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 0);
                end else if (!flush) begin
                    if (!sb[0].seen) begin
                        chk("latency", 32'(cyc), 32'(sb[0].due));
                        sb[0].seen = 1'b1;
                    end
                    chk("operation", 32'(Operation), 32'(sb[0].op));
                    chk("branch_type", 32'(branch_type), 32'(sb[0].bt));
`ifdef ALU_ILLEGAL_TRAP_EN
                    chk("illegal", 32'(illegal), 32'(sb[0].ill));
`endif
                    chk("ready_in_valid", 32'(in_ready), 32'(out_ready));
                    if (out_ready) begin
                        $display("txn cycle=%0d op=%b branch_type=%0d", cyc, Operation, branch_type);
                        void'(sb.pop_front());
                    end
                end
            end else begin
                if (multi_busy) chk("ready_busy", 32'(in_ready), 0);
                else chk("ready_idle", 32'(in_ready), 1);
                if (sb.size() > 0) begin
                    idle_cnt++;
                    if (idle_cnt > DIV_LAT + 4) begin
                        chk("output_timeout", 32'(out_valid), 1);
                        sb.delete();
                        idle_cnt = 0;
                    end
                end
            end
            if (flush) begin
                sb.delete();
                post_flush = 1'b1;
            end else if (in_valid && in_ready) begin
                sb.push_back(model(ALUOp, FuncField, cyc + 1));
                idle_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Presents one op and returns after the edge that accepted it.
    task automatic send(input logic [3:0] a, input logic [5:0] f, output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        in_valid  = 1'b1;
        ALUOp     = a;
        FuncField = f;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            waits++;
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        rt_map[6'b100000] = 4'b0000; rt_map[6'b100010] = 4'b0001;
        rt_map[6'b011000] = 4'b0010; rt_map[6'b011010] = 4'b0011;
        rt_map[6'b000000] = 4'b0100; rt_map[6'b000010] = 4'b0101;
        rt_map[6'b100100] = 4'b1000; rt_map[6'b100101] = 4'b1001;
        rt_map[6'b100110] = 4'b1010; rt_map[6'b100111] = 4'b1011;
        rt_map[6'b101010] = 4'b1110; rt_map[6'b100001] = 4'b0110;
        rt_map[6'b100011] = 4'b0111;

        #2;
        chk("reset_outputs", 32'({out_valid, multi_busy, Operation, branch_type}), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("reset_illegal", 32'(illegal), 0);
`endif
        step();
        rst_n = 1'b1;
        idle(2);

        // 1: add, one-cycle latency
        send(4'd2, 6'b100000, w);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_op", 32'(Operation), 32'h0);
        chk("add_bt", 32'(branch_type), 0);
        idle(3);

        // 2: mul stalls for MUL_LAT-1 cycles
        send(4'd2, 6'b011000, w);
        chk("mul_busy1", 32'({multi_busy, in_ready, out_valid}), 32'b100);
        step();
        chk("mul_busy2", 32'({multi_busy, in_ready, out_valid}), 32'b100);
        step();
        chk("mul_valid", 32'({multi_busy, out_valid}), 32'b01);
        chk("mul_op", 32'(Operation), 32'h2);
        idle(3);

        // 3: beq then andi back-to-back
        send(4'd4, 6'b000000, w);
        chk("beq_pair", 32'({Operation, branch_type}), 32'({4'b0001, 3'd1}));
        send(4'd1, 6'b000000, w);
        chk("andi_b2b_wait", 32'(w), 1);
        chk("andi_pair", 32'({Operation, branch_type}), 32'({4'b1000, 3'd0}));
        idle(3);

        // 4: EX backpressure holds outputs, release accepts the waiting op at once
        out_ready = 1'b0;
        send(4'd2, 6'b100010, w);
        in_valid  = 1'b1;
        ALUOp     = 4'd2;
        FuncField = 6'b100110;
        for (int i = 0; i < 4; i++) begin
            chk("hold_ready", 32'(in_ready), 0);
            chk("hold_state", 32'({out_valid, Operation, branch_type}), 32'({1'b1, 4'b0001, 3'd0}));
            step();
        end
        out_ready = 1'b1;
        send(4'd2, 6'b100110, w);
        chk("release_accept_wait", 32'(w), 1);
        chk("release_op", 32'(Operation), 32'hA);
        idle(3);

        // 5: flush in the middle of a div
        send(4'd2, 6'b011010, w);
        for (int i = 0; i < 3; i++) step();
        chk("div_busy_pre_flush", 32'({multi_busy, Operation}), 32'({1'b1, 4'b0011}));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("div_flushed", 32'({out_valid, multi_busy, Operation, branch_type}), 0);
        idle(12);

        // 6: unlisted funct and unlisted ALUOp
        send(4'd2, 6'b111111, w);
        chk("bad_funct_op", 32'(Operation), 0);
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("bad_funct_illegal", 32'(illegal), 1);
`endif
        send(4'd15, 6'b000000, w);
        chk("bad_aluop_op", 32'(Operation), 32'hF);
        send(4'd0, 6'b000000, w);
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("illegal_cleared", 32'(illegal), 0);
`endif
        idle(3);

        // Asynchronous reset while a div is in flight
        send(4'd2, 6'b011010, w);
        step();
        #2;
        chk("busy_before_reset", 32'({multi_busy, Operation}), 32'({1'b1, 4'b0011}));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({out_valid, multi_busy, Operation, branch_type}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(12);

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 40) == 0;
            in_valid  = $urandom % 2;
            ALUOp     = ($urandom % 2) ? 4'd2 : 4'($urandom % 16);
            FuncField = (($urandom % 8) == 0) ? 6'($urandom % 64) : fn_list[$urandom % 13];
            step();
        end
        flush = 1'b0;
        idle(15);
        chk("drain_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
